// File: rtl/writeback_arbiter.sv
// Merges completed results from several execute pipes onto one register-file write port.
// Define WRITEBACK_ARBITER_ROUND_ROBIN_EN for round-robin arbitration; default is fixed lowest-index priority.

module writeback_arbiter_lane #(
  parameter int unsigned AW = 5
) (
  input  logic          rst,
  input  logic          val,
  input  logic          wen,
  input  logic [AW-1:0] waddr,
  output logic          req,
  output logic          wr
);
  assign req = val & rst;
  // x0 is hardwired: the result still completes but never writes
  assign wr  = wen & (waddr != '0);
endmodule

module writeback_arbiter #(
  parameter int unsigned p_entry_bits = 32,
  parameter int unsigned p_num_regs   = 32,
  parameter int unsigned p_num_pipes  = 2,
  localparam int unsigned AW = $clog2(p_num_regs),
  localparam int unsigned PW = $clog2(p_num_pipes)
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [p_num_pipes-1:0]                  pipe_val,
  output logic [p_num_pipes-1:0]                  pipe_rdy,
  input  logic [p_num_pipes-1:0][AW-1:0]          pipe_waddr,
  input  logic [p_num_pipes-1:0][p_entry_bits-1:0] pipe_wdata,
  input  logic [p_num_pipes-1:0]                  pipe_wen,
  output logic [AW-1:0]                           waddr,
  output logic [p_entry_bits-1:0]                 wdata,
  output logic                                    wen
);
  typedef struct packed {
    logic                    wen;
    logic [AW-1:0]           waddr;
    logic [p_entry_bits-1:0] wdata;
  } wb_t;

  logic [p_num_pipes-1:0] req, wr, gnt;
  logic [PW-1:0]          gidx;
  logic                   found;
  wb_t                    wb_q;

  for (genvar i = 0; i < p_num_pipes; i++) begin : g_lane
    writeback_arbiter_lane #(.AW(AW)) u_lane (
      .rst   (rst),
      .val   (pipe_val[i]),
      .wen   (pipe_wen[i]),
      .waddr (pipe_waddr[i]),
      .req   (req[i]),
      .wr    (wr[i])
    );
  end

`ifdef WRITEBACK_ARBITER_ROUND_ROBIN_EN
  logic [PW-1:0] ptr;

  always_comb begin : scan
    int idx;
    gnt   = '0;
    gidx  = '0;
    found = 1'b0;
    for (int k = 0; k < int'(p_num_pipes); k++) begin
      idx = (int'(ptr) + k) % int'(p_num_pipes);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        gidx     = PW'(idx);
        found    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       ptr <= '0;
    else if (found) ptr <= (gidx == PW'(p_num_pipes - 1)) ? '0 : gidx + PW'(1);
  end
`else
  always_comb begin
    gnt   = '0;
    gidx  = '0;
    found = 1'b0;
    for (int i = 0; i < int'(p_num_pipes); i++) begin
      if (!found && req[i]) begin
        gnt[i] = 1'b1;
        gidx   = PW'(i);
        found  = 1'b1;
      end
    end
  end
`endif

  assign pipe_rdy = gnt;

  // Address/data only move on a transfer so idle cycles leave the last write visible
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_q <= '0;
    end else if (found) begin
      wb_q.wen   <= wr[gidx];
      wb_q.waddr <= pipe_waddr[gidx];
      wb_q.wdata <= pipe_wdata[gidx];
    end else begin
      wb_q.wen <= 1'b0;
    end
  end

  assign wen   = wb_q.wen;
  assign waddr = wb_q.waddr;
  assign wdata = wb_q.wdata;
endmodule
